// File: rtl/img_sram_io_subsystem_if.sv
// rtl/img_sram_io_subsystem_if.sv - pad-side control and pixel bus of the image SRAM subsystem
interface img_sram_io_subsystem_if;
  logic       connect_rx;
  logic       rx_en;
  logic       tx_en;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx_busy;
  logic       tx_busy;

  modport master (
    output connect_rx, rx_en, tx_en, nrows, ncols, din,
    input  dout, rx_busy, tx_busy
  );

  modport slave (
    input  connect_rx, rx_en, tx_en, nrows, ncols, din,
    output dout, rx_busy, tx_busy
  );
endinterface

// File: rtl/img_sram_io_subsystem.sv
// rtl/img_sram_io_subsystem.sv - banked 16K x 8 image SRAM with raster RX writer and TX reader
module img_sram_io_subsystem #(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 2,
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                rstn,
  img_sram_io_subsystem_if.slave io
);
  localparam logic [0:0] RX_IDLE   = 1'b0;
  localparam logic [0:0] RX_RECV   = 1'b1;
  localparam logic [1:0] TX_IDLE   = 2'd0;
  localparam logic [1:0] TX_READ   = 2'd1;
  localparam logic [1:0] TX_DRAIN1 = 2'd2;
  localparam logic [1:0] TX_DRAIN2 = 2'd3;
  localparam int         OFS_W     = ADDR_W - BANK_W;

  logic [15:0]       npix;
  logic              size_ok;
  logic [ADDR_W-1:0] last_idx;

  logic [0:0]        rx_state;
  logic [ADDR_W-1:0] rx_cnt;
  logic [ADDR_W-1:0] rx_last;
  logic [1:0]        tx_state;
  logic [ADDR_W-1:0] tx_cnt;
  logic [ADDR_W-1:0] tx_last;
  logic              tx_start;

  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] dout_sram;
  logic              rd_pend;
  logic [DATA_W-1:0] dout_q;

  logic [DATA_W-1:0] mem [2**BANK_W][2**OFS_W];

  // N = 16384 aliases to 0 in 14 bits, so N-1 still wraps to the correct last index.
  assign npix     = {8'd0, io.nrows} * {8'd0, io.ncols};
  assign size_ok  = (io.nrows != 8'd0) && (io.ncols != 8'd0) && (npix <= 16'd16384);
  assign last_idx = npix[ADDR_W-1:0] - ADDR_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_last  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (io.rx_en && size_ok) begin
            rx_state <= RX_RECV;
            rx_cnt   <= '0;
            rx_last  <= last_idx;
          end
        end
        default: begin
          if (rx_cnt == rx_last) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // Address 0 is issued on the start edge itself, so the counter leaves IDLE already at 1.
  assign tx_start = (tx_state == TX_IDLE) && io.tx_en && size_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_last  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_last  <= last_idx;
            tx_cnt   <= ADDR_W'(1);
            tx_state <= (last_idx == '0) ? TX_DRAIN1 : TX_READ;
          end
        end
        TX_READ: begin
          if (tx_cnt == tx_last) begin
            tx_state <= TX_DRAIN1;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + ADDR_W'(1);
          end
        end
        TX_DRAIN1: tx_state <= TX_DRAIN2;
        default:   tx_state <= TX_IDLE;
      endcase
    end
  end

  assign sram_cs    = io.connect_rx ? (rx_state == RX_RECV)
                                    : (tx_start || (tx_state == TX_READ));
  assign sram_we    = io.connect_rx;
  assign sram_addr  = io.connect_rx ? rx_cnt : ((tx_state == TX_READ) ? tx_cnt : '0);
  assign sram_wdata = io.din;

  always_ff @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        mem[sram_addr[ADDR_W-1 -: BANK_W]][sram_addr[OFS_W-1:0]] <= sram_wdata;
      end else begin
        dout_sram <= mem[sram_addr[ADDR_W-1 -: BANK_W]][sram_addr[OFS_W-1:0]];
      end
    end
  end

  // dout only advances on returned read data, so it holds the last pixel after a transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend <= 1'b0;
      dout_q  <= '0;
    end else begin
      rd_pend <= sram_cs && !sram_we;
      if (rd_pend) begin
        dout_q <= dout_sram;
      end
    end
  end

  assign io.dout    = dout_q;
  assign io.rx_busy = (rx_state != RX_IDLE);
  assign io.tx_busy = (tx_state != TX_IDLE);
endmodule

// File: tb/tb_img_sram_io_subsystem.sv
// tb/tb_img_sram_io_subsystem.sv - scoreboard bench for the image SRAM RX/TX subsystem
module tb_img_sram_io_subsystem;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] model [16384];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  img_sram_io_subsystem_if io ();

  img_sram_io_subsystem dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io)
  );

  task automatic check_eq(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       pat = 8'(i);
      1:       pat = 8'(8'hA0 + i);
      2:       pat = 8'(i * 7 + 3) ^ 8'(i >> 8);
      3:       pat = 8'h55 ^ 8'(i);
      default: pat = 8'hEE ^ 8'(i);
    endcase
  endfunction

  // rx_en is held for the start edge and one more edge; the second must be ignored.
  task automatic run_rx(input int nr, input int nc, input int mode);
    int n;
    n = nr * nc;
    io.nrows = 8'(nr);
    io.ncols = 8'(nc);
    io.rx_en = 1'b1;
    tick();
    check_eq("rx_busy_at_start", int'(io.rx_busy), 1);
    for (int k = 0; k < n; k++) begin
      io.din = pat(mode, k);
      tick();
      io.rx_en = 1'b0;
      if (io.connect_rx) model[k] = pat(mode, k);
      if (n <= 64 || k >= n - 2)
        check_eq("rx_busy_during", int'(io.rx_busy), (k == n - 1) ? 0 : 1);
    end
    tick();
    check_eq("rx_busy_after", int'(io.rx_busy), 0);
  endtask

  task automatic run_tx(input int nr, input int nc);
    int n;
    n = nr * nc;
    io.nrows = 8'(nr);
    io.ncols = 8'(nc);
    io.tx_en = 1'b1;
    tick();
    io.tx_en = 1'b0;
    check_eq("tx_busy_at_start", int'(io.tx_busy), 1);
    for (int k = 0; k < n; k++) exp_q.push_back(model[k]);
    for (int j = 1; j <= n + 1; j++) begin
      tick();
      if (j <= n) begin
        if (exp_q.size() == 0) check_eq("tx_queue_empty", 1, 0);
        else check_eq("tx_dout", int'(io.dout), int'(exp_q.pop_front()));
      end
      if (n <= 64 || j >= n - 1)
        check_eq("tx_busy", int'(io.tx_busy), (j <= n) ? 1 : 0);
    end
    tick();
    check_eq("tx_dout_hold", int'(io.dout), int'(model[n - 1]));
  endtask

  initial begin
    rstn          = 1'b0;
    io.connect_rx = 1'b1;
    io.rx_en      = 1'b0;
    io.tx_en      = 1'b0;
    io.nrows      = 8'd0;
    io.ncols      = 8'd0;
    io.din        = 8'd0;
    for (int i = 0; i < 16384; i++) model[i] = 8'd0;
    repeat (2) tick();
    check_eq("reset_rx_busy", int'(io.rx_busy), 0);
    check_eq("reset_tx_busy", int'(io.tx_busy), 0);
    check_eq("reset_dout", int'(io.dout), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Full 128x128 loopback also gives every address a known value for later tests.
    io.connect_rx = 1'b1;
    run_rx(128, 128, 0);
    io.connect_rx = 1'b0;
    run_tx(128, 128);

    io.connect_rx = 1'b1;
    run_rx(2, 3, 1);
    io.connect_rx = 1'b0;
    run_tx(1, 8);

    io.connect_rx = 1'b1;
    run_rx(64, 128, 2);
    io.connect_rx = 1'b0;
    run_tx(64, 128);
    check_eq("bank_edge_4095", int'(model[4095]), int'(pat(2, 4095)));
    check_eq("bank_edge_4096", int'(model[4096]), int'(pat(2, 4096)));

    io.connect_rx = 1'b1;
    io.nrows = 8'd1;
    io.ncols = 8'd64;
    io.rx_en = 1'b1;
    tick();
    io.rx_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      io.din = pat(3, k);
      tick();
      model[k] = pat(3, k);
    end
    rstn = 1'b0;
    #1;
    check_eq("reset_mid_rx_busy", int'(io.rx_busy), 0);
    check_eq("reset_mid_rx_dout", int'(io.dout), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    io.connect_rx = 1'b0;
    run_tx(1, 16);

    io.connect_rx = 1'b1;
    io.nrows = 8'd0;
    io.ncols = 8'd5;
    io.rx_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      io.din = 8'hC3;
      tick();
      check_eq("illegal_rows_rx_busy", int'(io.rx_busy), 0);
    end
    io.nrows = 8'd255;
    io.ncols = 8'd255;
    tick();
    check_eq("oversize_rx_busy", int'(io.rx_busy), 0);
    io.rx_en = 1'b0;
    io.connect_rx = 1'b0;
    io.nrows = 8'd4;
    io.ncols = 8'd0;
    io.tx_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("illegal_cols_tx_busy", int'(io.tx_busy), 0);
    end
    io.tx_en = 1'b0;
    run_tx(1, 16);

    io.connect_rx = 1'b0;
    run_rx(2, 3, 4);
    run_tx(1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
